// File: rtl/sram_sp_ctrl.sv
// ---------------------------------------------------------------------------
// sram_sp_ctrl
//   Single-port synchronous SRAM controller with a request handshake,
//   pipelined in-order reads and a self-clearing init sweep after every reset.
//
//   Optional feature macro: SRAM_PARITY_EN
//     When defined, each word carries an extra even-parity bit. Reads report
//     a mismatch on parity_err, and par_flip lets a writer corrupt the stored
//     parity bit. When undefined, storage is DATA_W bits per word and the
//     parity_err / par_flip ports do not exist.
//
//   Parameters
//     DATA_W    data word width
//     ADDR_W    address width
//     DEPTH     implemented words (1 <= DEPTH <= 2**ADDR_W)
//     RD_LAT    read latency from accept to rvalid (1 or 2)
//     INIT_VAL  value written to every word by the init sweep
//
//   Ports
//     clk         rising-edge clock
//     rst         asynchronous active-low reset
//     en          request valid
//     we          1 = write, 0 = read (sampled with en)
//     addr        word address
//     data_in     write data
//     par_flip    (parity build) invert the stored parity bit on this write
//     ready       controller accepts requests (IDLE)
//     data_out    read data; holds the last read value between reads
//     rvalid      one-cycle pulse marking valid data_out
//     init_done   init sweep finished; high until the next reset
//     parity_err  (parity build) parity mismatch on the current read
// ---------------------------------------------------------------------------
module sram_sp_ctrl #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                DEPTH    = 2**ADDR_W,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
`ifdef SRAM_PARITY_EN
    input  logic              par_flip,
    output logic              parity_err,
`endif
    output logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              init_done
);

`ifdef SRAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;

    // One extra bit so DEPTH == 2**ADDR_W is representable for the range check.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;

    logic [MEM_W-1:0]    mem [DEPTH];

    logic                in_range;
    logic                acc_wr;
    logic                acc_rd;
    logic                mem_we;
    logic [ADDR_W-1:0]   wr_idx;
    logic [MEM_W-1:0]    wr_word;
    logic [MEM_W-1:0]    rd_word;

    logic                vld_p0;
    logic [DATA_W-1:0]   dat_p0;

    function automatic logic par_even(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign acc_wr   = en && ready && we;
    assign acc_rd   = en && ready && !we;

    // The sweep owns the write port in INIT; out-of-range writes are dropped.
    assign mem_we   = (state == S_INIT) || (acc_wr && in_range);
    assign wr_idx   = (state == S_INIT) ? cnt : addr;

`ifdef SRAM_PARITY_EN
    assign wr_word  = (state == S_INIT) ? {par_even(INIT_VAL), INIT_VAL}
                                        : {par_even(data_in) ^ par_flip, data_in};
`else
    assign wr_word  = (state == S_INIT) ? INIT_VAL : data_in;
`endif

    // Out-of-range reads return all-zero, which also carries consistent parity.
    assign rd_word  = in_range ? mem[addr] : '0;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= wr_word;
        end
    end

    // Init sweep / handshake FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_INIT;
            cnt       <= '0;
            ready     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt == LAST) begin
                        state     <= S_IDLE;
                        ready     <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    ready     <= 1'b1;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    // Read stage p0: array read at the accepting edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            dat_p0 <= '0;
        end else begin
            vld_p0 <= acc_rd;
            if (acc_rd) begin
                dat_p0 <= rd_word[DATA_W-1:0];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic perr_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_p0 <= 1'b0;
        end else begin
            perr_p0 <= acc_rd && (^rd_word);
        end
    end
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              vld_p1;
            logic [DATA_W-1:0] dat_p1;

            // Read stage p1: extra output register
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_p1 <= 1'b0;
                    dat_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        dat_p1 <= dat_p0;
                    end
                end
            end

            assign rvalid   = vld_p1;
            assign data_out = dat_p1;

`ifdef SRAM_PARITY_EN
            logic perr_p1;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    perr_p1 <= 1'b0;
                end else begin
                    perr_p1 <= perr_p0;
                end
            end

            assign parity_err = perr_p1;
`endif
        end else begin : g_lat1
            assign rvalid   = vld_p0;
            assign data_out = dat_p0;
`ifdef SRAM_PARITY_EN
            assign parity_err = perr_p0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_sp_ctrl
//   Directed bench for sram_sp_ctrl. u1 uses the defaults (DEPTH=16,
//   RD_LAT=1); u2 uses DEPTH=12 and RD_LAT=2. Both share clock and reset.
// ---------------------------------------------------------------------------
module tb_sram_sp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       en1 = 1'b0, we1 = 1'b0;
    logic [3:0] addr1 = '0;
    logic [7:0] din1 = '0;
    logic       ready1, rvalid1, idone1;
    logic [7:0] dout1;

    logic       en2 = 1'b0, we2 = 1'b0;
    logic [3:0] addr2 = '0;
    logic [7:0] din2 = '0;
    logic       ready2, rvalid2, idone2;
    logic [7:0] dout2;

`ifdef SRAM_PARITY_EN
    logic       pflip1 = 1'b0, pflip2 = 1'b0;
    logic       perr1, perr2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_sp_ctrl u1 (
        .clk(clk), .rst(rst), .en(en1), .we(we1), .addr(addr1), .data_in(din1),
`ifdef SRAM_PARITY_EN
        .par_flip(pflip1), .parity_err(perr1),
`endif
        .ready(ready1), .data_out(dout1), .rvalid(rvalid1), .init_done(idone1)
    );

    sram_sp_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RD_LAT(2)) u2 (
        .clk(clk), .rst(rst), .en(en2), .we(we2), .addr(addr2), .data_in(din2),
`ifdef SRAM_PARITY_EN
        .par_flip(pflip2), .parity_err(perr2),
`endif
        .ready(ready2), .data_out(dout2), .rvalid(rvalid2), .init_done(idone2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr1(input logic [3:0] a, input logic [7:0] d);
        en1 = 1'b1; we1 = 1'b1; addr1 = a; din1 = d;
        tick();
        en1 = 1'b0; we1 = 1'b0;
    endtask

    task automatic rd1(input string tag, input logic [3:0] a, input logic [7:0] exp);
        en1 = 1'b1; we1 = 1'b0; addr1 = a;
        tick();
        en1 = 1'b0;
        chk1({tag, "_rvalid"}, rvalid1, 1'b1);
        chk8({tag, "_data"}, dout1, exp);
    endtask

    task automatic wr2(input logic [3:0] a, input logic [7:0] d, input logic flip);
        en2 = 1'b1; we2 = 1'b1; addr2 = a; din2 = d;
`ifdef SRAM_PARITY_EN
        pflip2 = flip;
`endif
        tick();
        en2 = 1'b0; we2 = 1'b0;
`ifdef SRAM_PARITY_EN
        pflip2 = 1'b0;
`else
        if (flip) $display("note: par_flip ignored without parity");
`endif
    endtask

    task automatic rd2(input string tag, input logic [3:0] a, input logic [7:0] exp,
                       input logic exp_perr);
        en2 = 1'b1; we2 = 1'b0; addr2 = a;
        tick();
        en2 = 1'b0;
        chk1({tag, "_early"}, rvalid2, 1'b0);
        tick();
        chk1({tag, "_rvalid"}, rvalid2, 1'b1);
        chk8({tag, "_data"}, dout2, exp);
`ifdef SRAM_PARITY_EN
        chk1({tag, "_perr"}, perr2, exp_perr);
`else
        if (exp_perr) $display("note: parity expectation skipped");
`endif
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk1("rst_ready1", ready1, 1'b0);
        chk1("rst_idone1", idone1, 1'b0);
        chk1("rst_rvalid1", rvalid1, 1'b0);
        chk8("rst_dout1", dout1, 8'h00);
        chk1("rst_ready2", ready2, 1'b0);
        chk1("rst_rvalid2", rvalid2, 1'b0);
        chk8("rst_dout2", dout2, 8'h00);

        // Init sweep: u1 ready after 16 edges, u2 after 12; a write attempt
        // during INIT cycle 5 must be ignored.
        rst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i == 5) begin
                en1 = 1'b1; we1 = 1'b1; addr1 = 4'd5; din1 = 8'hFF;
            end else begin
                en1 = 1'b0; we1 = 1'b0;
            end
            tick();
            chk1("init_ready1", ready1, i >= 16);
            chk1("init_idone1", idone1, i >= 16);
            chk1("init_rvalid1", rvalid1, 1'b0);
            chk1("init_ready2", ready2, i >= 12);
        end
        en1 = 1'b0; we1 = 1'b0;

        // Back-to-back reads of the whole u1 array after init
        for (int a = 0; a < 16; a++) begin
            rd1("init_rd", 4'(a), 8'h00);
        end
        tick();
        chk1("rd_pulse_end", rvalid1, 1'b0);

        // Write then read same address on next cycle
        wr1(4'd3, 8'hA5);
        chk1("wr_no_rvalid", rvalid1, 1'b0);
        chk8("wr_dout_hold", dout1, 8'h00);
        rd1("wr_rd3", 4'd3, 8'hA5);
        tick();
        chk1("rd3_pulse_end", rvalid1, 1'b0);
        chk8("rd3_hold", dout1, 8'hA5);
        rd1("rd5_after_init_wr", 4'd5, 8'h00);

        // RD_LAT=2 back-to-back reads
        wr2(4'd0, 8'h11, 1'b0);
        wr2(4'd1, 8'h22, 1'b0);
        wr2(4'd2, 8'h33, 1'b0);
        wr2(4'd3, 8'h44, 1'b0);
        en2 = 1'b1; we2 = 1'b0; addr2 = 4'd0;
        tick();
        chk1("lat2_first_early", rvalid2, 1'b0);
        addr2 = 4'd1;
        tick();
        chk1("lat2_v0", rvalid2, 1'b1);
        chk8("lat2_d0", dout2, 8'h11);
        addr2 = 4'd2;
        tick();
        chk1("lat2_v1", rvalid2, 1'b1);
        chk8("lat2_d1", dout2, 8'h22);
        addr2 = 4'd3;
        tick();
        chk1("lat2_v2", rvalid2, 1'b1);
        chk8("lat2_d2", dout2, 8'h33);
        en2 = 1'b0;
        tick();
        chk1("lat2_v3", rvalid2, 1'b1);
        chk8("lat2_d3", dout2, 8'h44);
        tick();
        chk1("lat2_end", rvalid2, 1'b0);
        chk8("lat2_hold", dout2, 8'h44);

        // Out-of-range address on DEPTH=12
        wr2(4'd14, 8'h5A, 1'b0);
        rd2("oor14", 4'd14, 8'h00, 1'b0);

`ifdef SRAM_PARITY_EN
        wr2(4'd2, 8'h3C, 1'b1);
        rd2("par_flip1", 4'd2, 8'h3C, 1'b1);
        wr2(4'd2, 8'h3C, 1'b0);
        rd2("par_flip0", 4'd2, 8'h3C, 1'b0);
`endif

        // Reset during an in-flight read
        wr2(4'd3, 8'h77, 1'b0);
        en2 = 1'b1; we2 = 1'b0; addr2 = 4'd3;
        tick();
        en2 = 1'b0;
        rst = 1'b0;
        #1;
        chk1("mid_rst_rvalid2", rvalid2, 1'b0);
        chk1("mid_rst_ready2", ready2, 1'b0);
        chk1("mid_rst_idone2", idone2, 1'b0);
        chk8("mid_rst_dout2", dout2, 8'h00);
        chk8("mid_rst_dout1", dout1, 8'h00);
        tick();
        chk1("mid_rst_no_rvalid", rvalid2, 1'b0);
        rst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk1("reinit_rvalid2", rvalid2, 1'b0);
            chk1("reinit_ready1", ready1, i >= 16);
            chk1("reinit_ready2", ready2, i >= 12);
        end
        rd1("reinit_rd3_u1", 4'd3, 8'h00);
        rd2("reinit_rd3_u2", 4'd3, 8'h00, 1'b0);
        rd2("reinit_rd0_u2", 4'd0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
